mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Multi-cycle MIPS32 control unit: a Moore FSM sequencing fetch, decode, execute, memory and writeback for R-type, LW, SW, BEQ, ADDI and J.
- Supersedes the single-cycle opcode decoder.
- Adds wait-state memory handshake, illegal-opcode trap, parametrised opcode encodings and retired-instruction/cycle counters.
- Sits beside the multi-cycle datapath; drives all datapath muxes and enables.

Parameters:
- OP_W, 6, opcode width
- CNT_W, 32, width of instret and cycle counters
- OP_R, 6'h00, R-type opcode
- OP_LW, 6'h23, load word
- OP_SW, 6'h2B, store word
- OP_BEQ, 6'h04, branch if equal
- OP_ADDI, 6'h08, add immediate
- OP_J, 6'h02, jump

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OP_W  instruction[31:26] from instruction register
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero
- iord  out  1  0=PC, 1=ALUOut address
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback source 1=MDR
- reg_dst  out  1  1=rd, 0=rt
- reg_wr  out  1  register file write
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  00=B, 01=4, 10=signext imm, 11=imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct
- pc_src  out  2  00=ALU, 01=ALUOut, 10=jump target
- illegal_op  out  1  one-cycle pulse on unknown opcode
- state  out  4  current state encoding, debug
- instret  out  CNT_W  retired instruction count
- cycles  out  CNT_W  cycles since reset

Behaviour:
- Async reset: state=IDLE, instret=0, cycles=0.
- Outputs are pure functions of state (Moore). Every output not listed for a state is 0.
- State encodings:
  - IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6
  - EXEC=7, ALUWB=8, BRANCH=9, ADDIEX=10, ADDIWB=11, JUMP=12, TRAP=13
- IDLE: all outputs 0. Goes to FETCH on the first clk after rst_n deasserts.
- FETCH:
  - Outputs: mem_rd=1, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write=1 and pc_write=1 only while mem_ready=1; these two outputs depend on mem_ready in this state only.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_b=11, alu_op=00 (branch target precompute).
  - Next state: OP_LW/OP_SW→MEMADR, OP_R→EXEC, OP_BEQ→BRANCH, OP_ADDI→ADDIEX, OP_J→JUMP, any other→TRAP.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: LW→MEMRD, SW→MEMWR. Opcode is held stable by the IR.
- MEMRD: mem_rd=1, iord=1. Stays until mem_ready=1, then MEMWB.
- MEMWB: reg_wr=1, mem_to_reg=1, reg_dst=0. Next: FETCH; instruction retires.
- MEMWR: mem_wr=1, iord=1. Stays until mem_ready=1, then FETCH; instruction retires.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB: reg_wr=1, reg_dst=1. Next: FETCH; instruction retires.
- BRANCH: alu_src_a=1, alu_op=01, pc_write_cond=1, pc_src=01. Next: FETCH; instruction retires.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
- ADDIWB: reg_wr=1, reg_dst=0. Next: FETCH; instruction retires.
- JUMP: pc_write=1, pc_src=10. Next: FETCH; instruction retires.
- TRAP: illegal_op=1 for exactly one cycle, no register or memory writes. Next: FETCH; not counted in instret.
- Cycle counts with mem_ready tied 1:
  - R=4, LW=5, SW=4, BEQ=3, ADDI=4, J=3
  - Each wait cycle adds one.
- instret: increments by 1 on the clock edge leaving a retiring state (MEMWB, MEMWR with mem_ready=1, ALUWB, BRANCH, ADDIWB, JUMP). Wraps modulo 2^CNT_W.
- cycles: increments every clock when state≠IDLE. Wraps modulo 2^CNT_W.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Reset mid-instruction (including during a memory wait) returns to IDLE immediately. No write enable may remain asserted during reset.
- mem_rd and mem_wr are never asserted together. reg_wr and mem_wr are never asserted together.

Test Plan:
- Reset then R-type (opcode 00), mem_ready=1 → states 0,1,2,7,8,1. reg_wr=1 and reg_dst=1 in state 8. instret=1 after 5 clocks.
- LW (6'h23) with mem_ready low for 3 cycles in MEMRD → MEMRD held 4 cycles. reg_wr=1 and mem_to_reg=1 once in MEMWB. 8 cycles total from FETCH.
- SW (6'h2B) then BEQ (6'h04) → mem_wr=1 with iord=1 in MEMWR. pc_write_cond=1, alu_op=01 in BRANCH. instret=2 after 7 clocks.
- Opcode 6'h3F → TRAP. illegal_op pulses exactly 1 cycle. No reg_wr or mem_wr asserted. instret unchanged. Back to FETCH.
- rst_n low during MEMWR wait → state=0 and all outputs 0 asynchronously. instret=0, cycles=0. Restarts at FETCH.
- CNT_W=4, run 16 J instructions (6'h02) → instret wraps from 15 to 0. pc_src=10 and pc_write=1 in each JUMP.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
// Control-unit bus: opcode and memory handshake in, datapath controls and
// debug counters out. The control unit is the master; the datapath is the slave.
interface mips_multicycle_control_if #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
);
    logic [OP_W-1:0]  opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_write_cond;
    logic             iord;
    logic             mem_rd;
    logic             mem_wr;
    logic             ir_write;
    logic             mem_to_reg;
    logic             reg_dst;
    logic             reg_wr;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_src;
    logic             illegal_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;
    logic [CNT_W-1:0] cycles;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, iord, mem_rd, mem_wr, ir_write,
               mem_to_reg, reg_dst, reg_wr, alu_src_a, alu_src_b, alu_op,
               pc_src, illegal_op, state, instret, cycles
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_rd, mem_wr, ir_write,
               mem_to_reg, reg_dst, reg_wr, alu_src_a, alu_src_b, alu_op,
               pc_src, illegal_op, state, instret, cycles
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS32 control FSM (Moore, except FETCH's IR/PC load which
// follows mem_ready so a stalled fetch never latches a stale word).
// Also keeps retired-instruction and active-cycle counters.
module mips_multicycle_control #(
    parameter int              OP_W    = 6,
    parameter int              CNT_W   = 32,
    parameter logic [OP_W-1:0] OP_R    = 6'h00,
    parameter logic [OP_W-1:0] OP_LW   = 6'h23,
    parameter logic [OP_W-1:0] OP_SW   = 6'h2B,
    parameter logic [OP_W-1:0] OP_BEQ  = 6'h04,
    parameter logic [OP_W-1:0] OP_ADDI = 6'h08,
    parameter logic [OP_W-1:0] OP_J    = 6'h02
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mips_multicycle_control_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB  = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
        S_JUMP   = 4'd12, S_TRAP   = 4'd13
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_instret;
    logic [CNT_W-1:0] r_cycles;

    // State register; reset drops straight back to IDLE, even mid-wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state decode. MEMADR re-checks the opcode, which the IR holds.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                if (bus.opcode == OP_LW || bus.opcode == OP_SW) w_next = S_MEMADR;
                else if (bus.opcode == OP_R)                     w_next = S_EXEC;
                else if (bus.opcode == OP_BEQ)                   w_next = S_BRANCH;
                else if (bus.opcode == OP_ADDI)                  w_next = S_ADDIEX;
                else if (bus.opcode == OP_J)                     w_next = S_JUMP;
                else                                             w_next = S_TRAP;
            end
            S_MEMADR: begin
                if (bus.opcode == OP_LW)      w_next = S_MEMRD;
                else if (bus.opcode == OP_SW) w_next = S_MEMWR;
                else                          w_next = S_TRAP;
            end
            S_MEMRD:  if (bus.mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) w_next = S_FETCH;
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP, S_TRAP:
                      w_next = S_FETCH;
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath controls as a function of state; anything not set stays 0.
    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_rd        = 1'b0;
        bus.mem_wr        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.reg_wr        = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = 2'b00;
        bus.alu_op        = 2'b00;
        bus.pc_src        = 2'b00;
        bus.illegal_op    = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.mem_rd    = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: bus.alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                bus.mem_rd = 1'b1;
                bus.iord   = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_wr     = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_wr = 1'b1;
                bus.iord   = 1'b1;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                bus.reg_wr  = 1'b1;
                bus.reg_dst = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_write_cond = 1'b1;
                bus.pc_src        = 2'b01;
            end
            S_ADDIWB: bus.reg_wr = 1'b1;
            S_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 2'b10;
            end
            S_TRAP:   bus.illegal_op = 1'b1;
            default: ;
        endcase
    end

    // An instruction retires on the edge that leaves its final state.
    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_retire = 1'b1;
            S_MEMWR: w_retire = bus.mem_ready;
            default: w_retire = 1'b0;
        endcase
    end

    // Free-running counters, both wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
            r_cycles  <= '0;
        end else begin
            if (w_retire)          r_instret <= r_instret + CNT_ONE;
            if (r_state != S_IDLE) r_cycles  <= r_cycles + CNT_ONE;
        end
    end

    assign bus.state   = r_state;
    assign bus.instret = r_instret;
    assign bus.cycles  = r_cycles;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: each test queues the expected state walk (with the
// opcode/mem_ready to drive in that cycle); the drain loop drives, then checks
// state, every control output and both counters against a spec-derived model.
module tb_mips_multicycle_control;
    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    mips_multicycle_control_if #(.OP_W(6), .CNT_W(32)) bus ();
    mips_multicycle_control_if #(.OP_W(6), .CNT_W(4))  bus4 ();

    mips_multicycle_control #(.OP_W(6), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    mips_multicycle_control #(.OP_W(6), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [5:0] op;
    } ent_t;

    ent_t        sb_q[$];
    logic [31:0] m_instret = '0;
    logic [31:0] m_cycles  = '0;

    // {pc_write, pc_write_cond, iord, mem_rd, mem_wr, ir_write, mem_to_reg,
    //  reg_dst, reg_wr, alu_src_a, alu_src_b, alu_op, pc_src, illegal_op}
    function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr);
        logic pw, pwc, io, rd, wr, irw, m2r, rdst, rw, asa, ill;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, io, rd, wr, irw, m2r, rdst, rw, asa, ill} = '0;
        {asb, aop, psrc} = '0;
        case (st)
            4'd1:  begin rd = 1; asb = 2'b01; irw = mr; pw = mr; end
            4'd2:  asb = 2'b11;
            4'd3:  begin asa = 1; asb = 2'b10; end
            4'd4:  begin rd = 1; io = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin wr = 1; io = 1; end
            4'd7:  begin asa = 1; aop = 2'b10; end
            4'd8:  begin rw = 1; rdst = 1; end
            4'd9:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
            4'd12: begin pw = 1; psrc = 2'b10; end
            4'd13: ill = 1;
            default: ;
        endcase
        return {pw, pwc, io, rd, wr, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
    endfunction

    function automatic logic [16:0] act_ctrl();
        return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_rd, bus.mem_wr,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_wr, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_src, bus.illegal_op};
    endfunction

    function automatic logic retiring(input logic [3:0] st, input logic mr);
        return (st == 4'd5) || (st == 4'd8) || (st == 4'd9) || (st == 4'd11) ||
               (st == 4'd12) || (st == 4'd6 && mr);
    endfunction

    task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] op);
        ent_t e;
        e.st = st; e.mr = mr; e.op = op;
        sb_q.push_back(e);
    endtask

    // Expected state walk for one instruction, with optional wait cycles.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(4'd1, 1'b0, op);
        push(4'd1, 1'b1, op);
        push(4'd2, 1'b1, op);
        case (op)
            6'h00: begin push(4'd7, 1'b1, op); push(4'd8, 1'b1, op); end
            6'h23: begin
                push(4'd3, 1'b1, op);
                for (int i = 0; i < mw; i++) push(4'd4, 1'b0, op);
                push(4'd4, 1'b1, op);
                push(4'd5, 1'b1, op);
            end
            6'h2B: begin
                push(4'd3, 1'b1, op);
                for (int i = 0; i < mw; i++) push(4'd6, 1'b0, op);
                push(4'd6, 1'b1, op);
            end
            6'h04: push(4'd9, 1'b1, op);
            6'h08: begin push(4'd10, 1'b1, op); push(4'd11, 1'b1, op); end
            6'h02: push(4'd12, 1'b1, op);
            default: push(4'd13, 1'b1, op);
        endcase
    endtask

    task automatic sb_drain();
        ent_t        e;
        logic [16:0] ec;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            bus.opcode    = e.op;
            bus.mem_ready = e.mr;
            #1;
            ec = exp_ctrl(e.st, e.mr);
            n_tests++;
            if (bus.state !== e.st) begin
                n_fail++;
                $display("FAIL state t=%0t: got %0d want %0d", $time, bus.state, e.st);
            end
            n_tests++;
            if (act_ctrl() !== ec) begin
                n_fail++;
                $display("FAIL ctrl t=%0t st=%0d: got %b want %b", $time, e.st, act_ctrl(), ec);
            end
            n_tests++;
            if (bus.instret !== m_instret) begin
                n_fail++;
                $display("FAIL instret t=%0t: got %0d want %0d", $time, bus.instret, m_instret);
            end
            n_tests++;
            if (bus.cycles !== m_cycles) begin
                n_fail++;
                $display("FAIL cycles t=%0t: got %0d want %0d", $time, bus.cycles, m_cycles);
            end
            if (retiring(e.st, e.mr)) m_instret = m_instret + 1;
            if (e.st != 4'd0)         m_cycles  = m_cycles + 1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (bus.state !== 4'd0 || act_ctrl() !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_out: state %0d ctrl %b want 0/0", bus.state, act_ctrl());
        end
        n_tests++;
        if (bus.instret !== 32'd0 || bus.cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: instret %0d cycles %0d want 0/0", bus.instret, bus.cycles);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        push(4'd0, 1'b1, 6'h00);
        sb_drain();
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 0, 0);
        sb_drain();
        n_tests++;
        if (bus.instret !== 32'd1) begin
            n_fail++;
            $display("FAIL rtype_instret: got %0d want 1", bus.instret);
        end
    endtask

    task automatic test_lw_wait();
        logic [31:0] c0;
        c0 = m_cycles;
        run_instr(6'h23, 0, 3);
        sb_drain();
        n_tests++;
        if (bus.cycles !== c0 + 32'd8) begin
            n_fail++;
            $display("FAIL lw_cycles: got %0d want %0d", bus.cycles, c0 + 32'd8);
        end
    endtask

    task automatic test_sw_beq();
        logic [31:0] i0;
        i0 = m_instret;
        run_instr(6'h2B, 0, 0);
        run_instr(6'h04, 0, 0);
        sb_drain();
        n_tests++;
        if (bus.instret !== i0 + 32'd2) begin
            n_fail++;
            $display("FAIL sw_beq_instret: got %0d want %0d", bus.instret, i0 + 32'd2);
        end
    endtask

    task automatic test_back_to_back();
        run_instr(6'h08, 2, 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h23, 1, 0);
        run_instr(6'h2B, 0, 2);
        sb_drain();
    endtask

    task automatic test_trap();
        logic [31:0] i0;
        i0 = m_instret;
        run_instr(6'h3F, 0, 0);
        sb_drain();
        n_tests++;
        if (bus.instret !== i0 || bus.state !== 4'd1 || bus.illegal_op !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_after: instret %0d state %0d ill %b want %0d/1/0",
                     bus.instret, bus.state, bus.illegal_op, i0);
        end
    endtask

    task automatic test_reset_mid();
        push(4'd1, 1'b1, 6'h2B);
        push(4'd2, 1'b1, 6'h2B);
        push(4'd3, 1'b1, 6'h2B);
        push(4'd6, 1'b0, 6'h2B);
        push(4'd6, 1'b0, 6'h2B);
        sb_drain();
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.state !== 4'd0 || act_ctrl() !== 17'd0) begin
            n_fail++;
            $display("FAIL midreset_out: state %0d ctrl %b want 0/0", bus.state, act_ctrl());
        end
        n_tests++;
        if (bus.instret !== 32'd0 || bus.cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL midreset_cnt: instret %0d cycles %0d want 0/0", bus.instret, bus.cycles);
        end
        #2 rst_n = 1'b1;
        m_instret = '0;
        m_cycles  = '0;
        push(4'd0, 1'b1, 6'h00);
        run_instr(6'h00, 0, 0);
        sb_drain();
    endtask

    task automatic test_wrap();
        logic [3:0] ei, ec;
        rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus4.state !== 4'd1 || bus4.instret !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_start: state %0d instret %0d want 1/0", bus4.state, bus4.instret);
        end
        for (int j = 0; j < 16; j++) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            n_tests++;
            if (bus4.state !== 4'd12 || bus4.pc_write !== 1'b1 || bus4.pc_src !== 2'b10) begin
                n_fail++;
                $display("FAIL wrap_jump[%0d]: state %0d pc_write %b pc_src %b want 12/1/10",
                         j, bus4.state, bus4.pc_write, bus4.pc_src);
            end
            @(posedge clk); #1;
            ei = 4'((j + 1) % 16);
            ec = 4'(((j + 1) * 3) % 16);
            n_tests++;
            if (bus4.instret !== ei || bus4.cycles !== ec) begin
                n_fail++;
                $display("FAIL wrap_cnt[%0d]: instret %0d cycles %0d want %0d/%0d",
                         j, bus4.instret, bus4.cycles, ei, ec);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.opcode     = 6'h00;
        bus.mem_ready  = 1'b0;
        bus4.opcode    = 6'h02;
        bus4.mem_ready = 1'b1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_beq();
        test_back_to_back();
        test_trap();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
